// File: rtl/fifo_sync_param.sv
// -----------------------------------------------------------------------------
// fifo_sync_param
//
// Synchronous single-clock FIFO for producer/consumer queues in the datapath.
// The FIFO has a fill-level count, full/empty flags, programmable
// almost-full/almost-empty thresholds and sticky overflow/underflow flags.
// The q output can be registered-read (FWFT=0) or first-word-fall-through
// (FWFT=1).
//
// Parameters
//   WIDTH    : data word width (>=1)
//   DEPTH    : number of entries (power of two, >=2)
//   AW       : pointer width, derived from DEPTH
//   AF_LEVEL : almost_full  when usedw >= AF_LEVEL (1..DEPTH)
//   AE_LEVEL : almost_empty when usedw <= AE_LEVEL (0..DEPTH-1)
//   FWFT     : 0 = registered read, 1 = first-word-fall-through
//
// Ports
//   clk          : clock, all state changes on the rising edge
//   rst          : synchronous active-high reset; drops all requests
//   data         : write data
//   wrreq        : write request (ignored while full)
//   rdreq        : read request / pop (ignored while empty)
//   err_clr      : clears overflow/underflow (a new error in the same cycle wins)
//   q            : read data
//   empty, full  : usedw == 0 / usedw == DEPTH
//   almost_full  : usedw >= AF_LEVEL
//   almost_empty : usedw <= AE_LEVEL
//   usedw        : number of stored words, 0..DEPTH
//   overflow     : sticky, write requested while full
//   underflow    : sticky, read requested while empty
// -----------------------------------------------------------------------------
module fifo_sync_param #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int AW       = $clog2(DEPTH),
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  parameter int FWFT     = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data,
  input  logic             wrreq,
  input  logic             rdreq,
  input  logic             err_clr,
  output logic [WIDTH-1:0] q,
  output logic             empty,
  output logic             full,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [AW:0]      usedw,
  output logic             overflow,
  output logic             underflow
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] AF_C    = (AW+1)'(AF_LEVEL);
  localparam logic [AW:0] AE_C    = (AW+1)'(AE_LEVEL);

  // Storage: not reset, so it maps onto block/distributed RAM.
  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [AW:0]   count_reg, count_next;
  logic          overflow_reg, overflow_next;
  logic          underflow_reg, underflow_next;
  logic          wr_acc, rd_acc;

  // Flags are decodes of the registered count only. Pointer equality is
  // ambiguous between full and empty, so the count alone decides both.
  assign empty        = (count_reg == '0);
  assign full         = (count_reg == DEPTH_C);
  assign almost_full  = (count_reg >= AF_C);
  assign almost_empty = (count_reg <= AE_C);
  assign usedw        = count_reg;
  assign overflow     = overflow_reg;
  assign underflow    = underflow_reg;

  // Accept decisions use the pre-edge flags. When full, a simultaneous read
  // still frees a slot, but the write is rejected anyway. This keeps the
  // accept path free of a same-cycle rdreq -> wrreq dependency.
  assign wr_acc = wrreq & ~full;
  assign rd_acc = rdreq & ~empty;

  always_comb begin
    wr_ptr_next    = wr_ptr_reg;
    rd_ptr_next    = rd_ptr_reg;
    count_next     = count_reg;
    overflow_next  = overflow_reg & ~err_clr;
    underflow_next = underflow_reg & ~err_clr;

    if (wr_acc) begin
      wr_ptr_next = wr_ptr_reg + AW'(1);
    end
    if (rd_acc) begin
      rd_ptr_next = rd_ptr_reg + AW'(1);
    end

    case ({wr_acc, rd_acc})
      2'b10:   count_next = count_reg + (AW+1)'(1);
      2'b01:   count_next = count_reg - (AW+1)'(1);
      default: count_next = count_reg;
    endcase

    // A new error event takes priority over err_clr in the same cycle.
    if (wrreq & full) begin
      overflow_next = 1'b1;
    end
    if (rdreq & empty) begin
      underflow_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      wr_ptr_reg    <= wr_ptr_next;
      rd_ptr_reg    <= rd_ptr_next;
      count_reg     <= count_next;
      overflow_reg  <= overflow_next;
      underflow_reg <= underflow_next;
    end
  end

  // Write port. Reset drops an in-flight write, but the old contents stay.
  always_ff @(posedge clk) begin
    if (!rst && wr_acc) begin
      mem[wr_ptr_reg] <= data;
    end
  end

  // Read and write can never address the same slot in one cycle. A read
  // needs count > 0 and a write needs count < DEPTH, so the pointers are
  // never equal while both are accepted.
  generate
    if (FWFT != 0) begin : g_fwft
      // The head word is shown directly. rdreq acknowledges the word that
      // q already presents.
      assign q = empty ? '0 : mem[rd_ptr_reg];
    end else begin : g_std
      logic [WIDTH-1:0] q_reg;

      // Registered read. q holds its value unless a read is accepted.
      always_ff @(posedge clk) begin
        if (rst) begin
          q_reg <= '0;
        end else if (rd_acc) begin
          q_reg <= mem[rd_ptr_reg];
        end
      end

      assign q = q_reg;
    end
  endgenerate

endmodule

// File: tb/tb_fifo_sync_param.sv
// -----------------------------------------------------------------------------
// tb_fifo_sync_param
//
// Drives a standard-mode instance (WIDTH=8) and an FWFT instance (WIDTH=16)
// with shared stimulus. A directed table checks the 8-bit instance for
// fill, overflow, drain and underflow. Hand-written sequences cover the
// simultaneous-request, reset and FWFT corners. Randomised traffic is then
// compared against a queue-based model of each FIFO.
// -----------------------------------------------------------------------------
module tb_fifo_sync_param;

  logic        clk = 1'b0;
  logic        rst;
  logic        wrreq, rdreq, err_clr;
  logic [15:0] din;

  logic [7:0]  s_q;
  logic        s_empty, s_full, s_af, s_ae, s_ovf, s_unf;
  logic [4:0]  s_usedw;

  logic [15:0] f_q;
  logic        f_empty, f_full, f_af, f_ae, f_ovf, f_unf;
  logic [4:0]  f_usedw;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  fifo_sync_param #(.WIDTH(8), .DEPTH(16), .FWFT(0)) dut_std (
    .clk(clk), .rst(rst), .data(din[7:0]), .wrreq(wrreq), .rdreq(rdreq),
    .err_clr(err_clr), .q(s_q), .empty(s_empty), .full(s_full),
    .almost_full(s_af), .almost_empty(s_ae), .usedw(s_usedw),
    .overflow(s_ovf), .underflow(s_unf)
  );

  fifo_sync_param #(.WIDTH(16), .DEPTH(16), .FWFT(1)) dut_fwft (
    .clk(clk), .rst(rst), .data(din), .wrreq(wrreq), .rdreq(rdreq),
    .err_clr(err_clr), .q(f_q), .empty(f_empty), .full(f_full),
    .almost_full(f_af), .almost_empty(f_ae), .usedw(f_usedw),
    .overflow(f_ovf), .underflow(f_unf)
  );

  // ---------------- reference model (queues) ----------------
  logic [15:0] sq[$];
  logic [15:0] fq[$];
  logic [7:0]  sm_q;
  logic        sm_ovf, sm_unf, fm_ovf, fm_unf;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Advance both models using the pre-edge model state and current inputs.
  task automatic model_step();
    logic [15:0] popped;
    bit          mfull, mempty;
    if (rst) begin
      sq.delete();
      fq.delete();
      sm_q   = 8'h00;
      sm_ovf = 1'b0; sm_unf = 1'b0;
      fm_ovf = 1'b0; fm_unf = 1'b0;
    end else begin
      mfull  = (sq.size() == 16);
      mempty = (sq.size() == 0);
      sm_ovf = (sm_ovf & ~err_clr) | (wrreq & mfull);
      sm_unf = (sm_unf & ~err_clr) | (rdreq & mempty);
      if (rdreq && !mempty) begin
        popped = sq.pop_front();
        sm_q   = popped[7:0];
      end
      if (wrreq && !mfull) sq.push_back({8'h00, din[7:0]});

      mfull  = (fq.size() == 16);
      mempty = (fq.size() == 0);
      fm_ovf = (fm_ovf & ~err_clr) | (wrreq & mfull);
      fm_unf = (fm_unf & ~err_clr) | (rdreq & mempty);
      if (rdreq && !mempty) popped = fq.pop_front();
      if (wrreq && !mfull) fq.push_back(din);
    end
  endtask

  task automatic cmp_model();
    logic [15:0] fexp;
    int ss, fs;
    ss = sq.size();
    fs = fq.size();
    fexp = (fs == 0) ? 16'h0000 : fq[0];
    chk("std_usedw", 32'(s_usedw), 32'(ss));
    chk("std_empty", 32'(s_empty), 32'(ss == 0));
    chk("std_full",  32'(s_full),  32'(ss == 16));
    chk("std_af",    32'(s_af),    32'(ss >= 14));
    chk("std_ae",    32'(s_ae),    32'(ss <= 2));
    chk("std_q",     32'(s_q),     32'(sm_q));
    chk("std_ovf",   32'(s_ovf),   32'(sm_ovf));
    chk("std_unf",   32'(s_unf),   32'(sm_unf));
    chk("fw_usedw",  32'(f_usedw), 32'(fs));
    chk("fw_empty",  32'(f_empty), 32'(fs == 0));
    chk("fw_full",   32'(f_full),  32'(fs == 16));
    chk("fw_af",     32'(f_af),    32'(fs >= 14));
    chk("fw_ae",     32'(f_ae),    32'(fs <= 2));
    chk("fw_q",      32'(f_q),     32'(fexp));
    chk("fw_ovf",    32'(f_ovf),   32'(fm_ovf));
    chk("fw_unf",    32'(f_unf),   32'(fm_unf));
  endtask

  // One transaction: inputs already driven; clock edge, sample #1 later.
  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    cyc++;
    $display("cyc %0d rst=%0b wr=%0b rd=%0b clr=%0b d=%04h | std usedw=%0d q=%02h ovf=%0b unf=%0b | fwft usedw=%0d q=%04h",
             cyc, rst, wrreq, rdreq, err_clr, din, s_usedw, s_q, s_ovf, s_unf, f_usedw, f_q);
    cmp_model();
  endtask

  task automatic drive(input logic r, input logic w, input logic rd, input logic c, input logic [15:0] d);
    rst = r; wrreq = w; rdreq = rd; err_clr = c; din = d;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic       wr, rd, clr;
    logic [7:0] d;
    int         usedw;
    logic [7:0] q;
    logic       empty, full, af, ae, ovf, unf;
  } vec_t;

  vec_t tbl[37];

  initial begin
    // Fill 0x01..0x10, overflow, clear, drain, underflow, clear/set race.
    for (int i = 0; i < 16; i++) begin
      tbl[i] = '{wr:1, rd:0, clr:0, d:8'(i + 1), usedw:i + 1, q:8'h00,
                 empty:0, full:(i == 15), af:(i + 1 >= 14), ae:(i + 1 <= 2), ovf:0, unf:0};
    end
    tbl[16] = '{wr:1, rd:0, clr:0, d:8'h11, usedw:16, q:8'h00,
                empty:0, full:1, af:1, ae:0, ovf:1, unf:0};
    tbl[17] = '{wr:0, rd:0, clr:1, d:8'h00, usedw:16, q:8'h00,
                empty:0, full:1, af:1, ae:0, ovf:0, unf:0};
    for (int j = 0; j < 16; j++) begin
      tbl[18 + j] = '{wr:0, rd:1, clr:0, d:8'h00, usedw:15 - j, q:8'(j + 1),
                      empty:(j == 15), full:0, af:(15 - j >= 14), ae:(15 - j <= 2), ovf:0, unf:0};
    end
    tbl[34] = '{wr:0, rd:1, clr:0, d:8'h00, usedw:0, q:8'h10,
                empty:1, full:0, af:0, ae:1, ovf:0, unf:1};
    tbl[35] = '{wr:0, rd:1, clr:1, d:8'h00, usedw:0, q:8'h10,
                empty:1, full:0, af:0, ae:1, ovf:0, unf:1};
    tbl[36] = '{wr:0, rd:0, clr:1, d:8'h00, usedw:0, q:8'h10,
                empty:1, full:0, af:0, ae:1, ovf:0, unf:0};

    sm_q = 8'h00; sm_ovf = 0; sm_unf = 0; fm_ovf = 0; fm_unf = 0;

    // Reset with both requests asserted.
    drive(1, 1, 1, 0, 16'hFFFF);
    cycle();
    cycle();
    chk("rst_usedw", 32'(s_usedw), 32'd0);
    chk("rst_empty", 32'(s_empty), 32'd1);
    chk("rst_full",  32'(s_full),  32'd0);
    chk("rst_q",     32'(s_q),     32'd0);
    chk("rst_ovf",   32'(s_ovf),   32'd0);
    chk("rst_unf",   32'(s_unf),   32'd0);
    chk("rst_fq",    32'(f_q),     32'd0);
    chk("rst_fempty", 32'(f_empty), 32'd1);

    for (int i = 0; i < 37; i++) begin
      drive(0, tbl[i].wr, tbl[i].rd, tbl[i].clr, {8'h00, tbl[i].d});
      cycle();
      chk("tbl_usedw", 32'(s_usedw), 32'(tbl[i].usedw));
      chk("tbl_q",     32'(s_q),     32'(tbl[i].q));
      chk("tbl_empty", 32'(s_empty), 32'(tbl[i].empty));
      chk("tbl_full",  32'(s_full),  32'(tbl[i].full));
      chk("tbl_af",    32'(s_af),    32'(tbl[i].af));
      chk("tbl_ae",    32'(s_ae),    32'(tbl[i].ae));
      chk("tbl_ovf",   32'(s_ovf),   32'(tbl[i].ovf));
      chk("tbl_unf",   32'(s_unf),   32'(tbl[i].unf));
    end

    // Wrap: 10 writes, 10 reads, then 12 writes with overlapping reads.
    for (int k = 0; k < 10; k++) begin drive(0, 1, 0, 0, 16'(16'h0120 + k)); cycle(); end
    for (int k = 0; k < 10; k++) begin drive(0, 0, 1, 0, 16'h0000); cycle(); end
    for (int k = 0; k < 12; k++) begin drive(0, 1, (k >= 1), 0, 16'(16'h0230 + k)); cycle(); end
    drive(0, 0, 0, 0, 16'h0000);
    cycle();
    chk("wrap_usedw", 32'(s_usedw), 32'd1);

    // Simultaneous read/write at usedw=5.
    for (int k = 0; k < 4; k++) begin drive(0, 1, 0, 0, 16'(16'h0340 + k)); cycle(); end
    chk("mid_usedw_pre", 32'(s_usedw), 32'd5);
    drive(0, 1, 1, 0, 16'h0350);
    cycle();
    chk("mid_usedw", 32'(s_usedw), 32'd5);

    // Both requests when full: the read wins and overflow is set.
    for (int k = 0; k < 11; k++) begin drive(0, 1, 0, 0, 16'(16'h0460 + k)); cycle(); end
    chk("full_pre", 32'(s_full), 32'd1);
    drive(0, 1, 1, 0, 16'h04FF);
    cycle();
    chk("full_both_usedw", 32'(s_usedw), 32'd15);
    chk("full_both_ovf",   32'(s_ovf),   32'd1);
    drive(0, 0, 0, 1, 16'h0000);
    cycle();

    // Both requests when empty: the write wins and underflow is set.
    for (int k = 0; k < 15; k++) begin drive(0, 0, 1, 0, 16'h0000); cycle(); end
    chk("empty_pre", 32'(s_empty), 32'd1);
    drive(0, 1, 1, 0, 16'h0577);
    cycle();
    chk("empty_both_usedw", 32'(s_usedw), 32'd1);
    chk("empty_both_unf",   32'(s_unf),   32'd1);
    drive(0, 0, 0, 1, 16'h0000);
    cycle();

    // Reset mid-operation with a read in flight.
    drive(1, 0, 0, 0, 16'h0000);
    cycle();
    for (int k = 0; k < 7; k++) begin drive(0, 1, 0, 0, 16'(16'h0660 + k)); cycle(); end
    chk("rstmid_pre", 32'(s_usedw), 32'd7);
    drive(1, 0, 1, 0, 16'h0000);
    cycle();
    chk("rstmid_usedw", 32'(s_usedw), 32'd0);
    chk("rstmid_empty", 32'(s_empty), 32'd1);
    chk("rstmid_q",     32'(s_q),     32'd0);
    chk("rstmid_fq",    32'(f_q),     32'd0);
    drive(0, 1, 0, 0, 16'h00A5);
    cycle();
    drive(0, 0, 1, 0, 16'h0000);
    cycle();
    chk("rstmid_newdata", 32'(s_q), 32'h0000_00A5);

    // FWFT: a word written into an empty FIFO appears without rdreq.
    drive(0, 1, 0, 0, 16'hBEEF);
    cycle();
    chk("fwft_q",     32'(f_q),     32'h0000_BEEF);
    chk("fwft_empty", 32'(f_empty), 32'd0);
    drive(0, 0, 1, 0, 16'h0000);
    cycle();
    chk("fwft_pop_q",     32'(f_q),     32'd0);
    chk("fwft_pop_empty", 32'(f_empty), 32'd1);

    // Random traffic, alternating fill-biased and drain-biased phases.
    for (int k = 0; k < 1500; k++) begin
      int pw;
      pw = ((k / 60) % 2 == 0) ? 75 : 25;
      rst     = ($urandom_range(0, 199) == 0);
      wrreq   = ($urandom_range(0, 99) < pw);
      rdreq   = ($urandom_range(0, 99) < (100 - pw));
      err_clr = ($urandom_range(0, 99) < 4);
      din     = 16'($urandom);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
